// File: rtl/nco_seq_pkg.sv
// nco_seq_pkg: shared definitions for the NCO step sequencer.
//   - Control-word field layout (bit offsets/widths) of the 16-bit datapath word.
//   - Sequencer FSM state type.
package nco_seq_pkg;
  localparam int CTRL_W   = 16;
  localparam int FILT_BIT = 15;
  localparam int INCA_LSB = 8;
  localparam int INCA_W   = 7;
  localparam int BYPB_BIT = 7;
  localparam int AMPB_BIT = 6;
  localparam int INCB_LSB = 0;
  localparam int INCB_W   = 6;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} seq_state_e;

  // Field view of a control word, MSB first.
  typedef struct packed {
    logic              filter_on;
    logic [INCA_W-1:0] incr_a;
    logic              bypass_b;
    logic              amplitude_b;
    logic [INCB_W-1:0] incr_b;
  } ctrl_word_t;
endpackage

// File: rtl/seq_step_table.sv
// seq_step_table: NUM_STEPS x CTRL_W register file.
//   clk, rst_n      : clock, synchronous active-low reset (clears all entries)
//   we/waddr/wdata  : single write port
//   raddr/rdata     : combinational read port; returns pre-write data
module seq_step_table
  import nco_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [CTRL_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [CTRL_W-1:0] rdata
);
  logic [NUM_STEPS-1:0][CTRL_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst_n)  mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/nco_step_sequencer.sv
// nco_step_sequencer: plays a table of control words, each held step_len
// cycles, in loop or one-shot mode.
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_we/addr/data      : table write port (any state)
//   step_len              : hold length per step (0 behaves as 1), sampled at each load
//   last_step, loop       : final index; wrap to 0 (loop) or finish (one-shot)
//   start, stop           : playback control; stop wins over start
//   ctrl_out, step_idx    : registered current word and its index
//   step_strobe           : 1-cycle pulse after each load
//   busy, done            : PLAY indicator, one-shot completion pulse
module nco_step_sequencer
  import nco_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int LEN_W     = 16,
  parameter int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [CTRL_W-1:0] cfg_data,
  input  logic [LEN_W-1:0]  step_len,
  input  logic [IDX_W-1:0]  last_step,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [IDX_W-1:0]  step_idx,
  output logic              step_strobe,
  output logic              busy,
  output logic              done
);
  seq_state_e        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, len_m1;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_addr;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, rd_data;
  logic              strobe_q, strobe_d, done_q, done_d;

  // Next table index: advance unless at last_step (or idle), where it is 0.
  // idx+1 wraps naturally at NUM_STEPS-1 since the table depth is 2^IDX_W.
  assign rd_addr = (state_q == PLAY && idx_q != last_step) ? idx_q + 1'b1 : '0;
  // Counter holds L-1 so that a step stays up exactly L cycles; 0 acts as 1.
  assign len_m1  = (step_len == '0) ? '0 : step_len - 1'b1;

  seq_step_table #(.NUM_STEPS(NUM_STEPS), .IDX_W(IDX_W)) u_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ctrl_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ctrl_q   <= ctrl_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ctrl_d   = ctrl_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ctrl_d = '0;
        if (start && !stop) begin
          state_d  = PLAY;
          idx_d    = '0;
          ctrl_d   = rd_data;
          strobe_d = 1'b1;
          cnt_d    = len_m1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          ctrl_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q != last_step || loop) begin
          idx_d    = rd_addr;
          ctrl_d   = rd_data;
          strobe_d = 1'b1;
          cnt_d    = len_m1;
        end else begin
          state_d = IDLE;
          ctrl_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctrl_out    = ctrl_q;
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;
  assign busy        = (state_q == PLAY);
  assign done        = done_q;
endmodule

// File: tb/tb_nco_step_sequencer.sv
module tb_nco_step_sequencer;
  localparam int N     = 8;
  localparam int LEN_W = 16;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [15:0]      cfg_data;
  logic [LEN_W-1:0] step_len;
  logic [IDX_W-1:0] last_step;
  logic             loop, start, stop;
  logic [15:0]      ctrl_out;
  logic [IDX_W-1:0] step_idx;
  logic             step_strobe, busy, done;

  always #5 clk = ~clk;

  nco_step_sequencer #(.NUM_STEPS(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .step_len(step_len), .last_step(last_step),
    .loop(loop), .start(start), .stop(stop), .ctrl_out(ctrl_out),
    .step_idx(step_idx), .step_strobe(step_strobe), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: next load is scheduled at an absolute cycle number.
  logic [15:0] m_mem [N];
  logic [15:0] m_ctrl   = '0;
  int          m_idx    = 0;
  bit          m_play   = 1'b0;
  bit          m_strobe = 1'b0;
  bit          m_done   = 1'b0;
  longint      cyc      = 0;
  longint      m_next   = 0;

  always @(posedge clk) begin : model
    int     nidx;
    longint hold;
    hold = (step_len == 0) ? 1 : longint'(step_len);
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_mem[i] <= '0;
      m_ctrl <= '0; m_idx <= 0; m_play <= 1'b0; m_strobe <= 1'b0; m_done <= 1'b0;
    end else begin
      m_strobe <= 1'b0;
      m_done   <= 1'b0;
      if (!m_play) begin
        m_ctrl <= '0;
        if (start && !stop) begin
          m_play <= 1'b1; m_idx <= 0; m_ctrl <= m_mem[0];
          m_strobe <= 1'b1; m_next <= cyc + hold;
        end
      end else if (stop) begin
        m_play <= 1'b0; m_ctrl <= '0;
      end else if (cyc == m_next) begin
        if (m_idx == int'(last_step) && !loop) begin
          m_play <= 1'b0; m_ctrl <= '0; m_done <= 1'b1;
        end else begin
          nidx = (m_idx == int'(last_step)) ? 0 : (m_idx + 1) % N;
          m_idx <= nidx; m_ctrl <= m_mem[nidx];
          m_strobe <= 1'b1; m_next <= cyc + hold;
        end
      end
      if (cfg_we) m_mem[cfg_addr] <= cfg_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl_out", ctrl_out, m_ctrl);
      chk("step_strobe", step_strobe, m_strobe);
      chk("busy", busy, m_play);
      chk("done", done, m_done);
      if (m_play) chk("step_idx", step_idx, m_idx);
    end
  end

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_data = d;
    nxt;
    cfg_we = 1'b0;
  endtask

  task automatic go;
    start = 1'b1; nxt; start = 1'b0;
  endtask

  task automatic halt;
    stop = 1'b1; nxt; stop = 1'b0; nxt;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    step_len = '0; last_step = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    nxt; chk_en = 1'b1;
    nxt; nxt; rst_n = 1'b1; nxt;
    chk("rst ctrl_out", ctrl_out, 0);
    chk("rst busy", busy, 0);
    chk("rst step_strobe", step_strobe, 0);
    chk("rst step_idx", step_idx, 0);

    wr(0, 16'h8101); wr(1, 16'h0202); wr(2, 16'h0403); wr(3, 16'h0804);

    // Loop walk, L=3
    step_len = 3; last_step = 3; loop = 1'b1;
    go;
    for (int c = 0; c < 15; c++) begin
      case (c)
        0:  begin chk("walk c0", ctrl_out, 16'h8101); chk("walk c0 strobe", step_strobe, 1); end
        1:  chk("walk c1 strobe", step_strobe, 0);
        3:  chk("walk c3", ctrl_out, 16'h0202);
        6:  chk("walk c6", ctrl_out, 16'h0403);
        9:  begin chk("walk c9", ctrl_out, 16'h0804); chk("walk c9 strobe", step_strobe, 1); end
        12: chk("walk c12 wrap", ctrl_out, 16'h8101);
        default: ;
      endcase
      nxt;
    end
    halt;

    // One-shot
    loop = 1'b0;
    go;
    for (int c = 0; c < 14; c++) begin
      case (c)
        11: begin chk("oneshot c11", ctrl_out, 16'h0804); chk("oneshot c11 busy", busy, 1); end
        12: begin chk("oneshot c12", ctrl_out, 0); chk("oneshot done", done, 1); chk("oneshot busy", busy, 0); end
        13: chk("oneshot done pulse", done, 0);
        default: ;
      endcase
      nxt;
    end

    // L=0 and L=1: one cycle per step, strobe continuous
    loop = 1'b1;
    for (int l = 0; l < 2; l++) begin
      step_len = LEN_W'(l);
      go;
      for (int c = 0; c < 8; c++) begin
        chk("short strobe", step_strobe, 1);
        if (c == 2) chk("short c2", ctrl_out, 16'h0403);
        if (c == 5) chk("short c5", ctrl_out, 16'h0202);
        nxt;
      end
      halt;
    end

    // Stop two cycles into step 2, then start+stop together
    step_len = 3;
    go;
    for (int c = 0; c < 7; c++) nxt;
    stop = 1'b1; nxt; stop = 1'b0;
    chk("stop ctrl_out", ctrl_out, 0);
    chk("stop busy", busy, 0);
    chk("stop no done", done, 0);
    start = 1'b1; stop = 1'b1; nxt; start = 1'b0; stop = 1'b0;
    chk("start+stop busy", busy, 0);
    nxt;

    // Write colliding with the load of step 2
    go;
    for (int c = 0; c < 5; c++) nxt;
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 16'hFFFF; nxt; cfg_we = 1'b0;
    chk("collide old", ctrl_out, 16'h0403);
    for (int c = 6; c < 18; c++) nxt;
    chk("collide new", ctrl_out, 16'hFFFF);
    halt;

    // Reset mid-run
    go;
    for (int c = 0; c < 4; c++) nxt;
    rst_n = 1'b0; nxt; rst_n = 1'b1;
    chk("midrst ctrl_out", ctrl_out, 0);
    chk("midrst busy", busy, 0);
    nxt;
    step_len = 3; last_step = 3; loop = 1'b1;
    go;
    chk("post-rst busy", busy, 1);
    chk("post-rst c0", ctrl_out, 0);
    nxt; nxt; nxt;
    chk("post-rst c3", ctrl_out, 0);
    halt;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      cfg_we   = ($urandom_range(3) == 0);
      cfg_addr = IDX_W'($urandom_range(N - 1));
      cfg_data = 16'($urandom);
      if ($urandom_range(40) == 0) step_len  = LEN_W'($urandom_range(4));
      if ($urandom_range(40) == 0) last_step = IDX_W'($urandom_range(N - 1));
      if ($urandom_range(30) == 0) loop      = $urandom_range(1) == 1;
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(60) == 0);
      rst_n = ($urandom_range(700) != 0);
      nxt;
    end
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    nxt; nxt;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nco_step_sequencer.md
# nco_step_sequencer

Step sequencer that configures the dual-NCO ring-modulator datapath over time. It holds a small table of 16-bit control words, each packing filter enable, NCO A increment, NCO B bypass/amplitude and NCO B increment. It plays them back one after another, each for a programmable number of clock cycles, in loop or one-shot mode. It sits between the host configuration inputs and the datapath control registers; `ctrl_out` replaces direct pin-driven control.

## Interface
- `NUM_STEPS`, 8: table depth; must be a power of two, minimum 2.
- `LEN_W`, 16: width of the step-length counter.
- `IDX_W`, $clog2(NUM_STEPS): step index width (derived; not overridden).

- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  IDX_W  table write address.
- `cfg_data`  in  16  control word, packed as `{filter_on, incr_A[6:0], bypass_B, amplitude_B, incr_B[5:0]}` (bit 15 down to bit 0).
- `step_len`  in  LEN_W  cycles each step is held. The value 0 is treated as 1.
- `last_step`  in  IDX_W  index of the final step before wrap or finish.
- `loop`  in  1  1 = wrap to step 0 after `last_step`; 0 = one-shot.
- `start`  in  1  start playback (level is sampled each cycle).
- `stop`  in  1  abort playback.
- `ctrl_out`  out  16  current control word, fed to the datapath.
- `step_idx`  out  IDX_W  index of the step currently shown on `ctrl_out`.
- `step_strobe`  out  1  one-cycle pulse on the cycle `ctrl_out` takes a new table value.
- `busy`  out  1  high while in PLAY.
- `done`  out  1  one-cycle pulse when a one-shot run completes.

## Operation
- **Reset.** All table entries, `ctrl_out`, `step_idx`, `step_strobe`, `busy`, `done` and the counter clear to 0. State goes to IDLE.
- **FSM states:** IDLE and PLAY.
- **IDLE:**
  - `ctrl_out` = 0 and `busy` = 0.
  - `start`=1 (with `stop`=0) → PLAY. On the same edge: `ctrl_out` ← table[0], `step_idx` ← 0, `step_strobe` ← 1, counter ← max(`step_len`,1)−1.
- **PLAY, counter ≠ 0:** counter decrements; outputs hold.
- **PLAY, counter = 0, `step_idx` ≠ `last_step`:**
  - Advance: `step_idx`+1, load table[`step_idx`+1], pulse `step_strobe`.
  - Counter reloads from the current `step_len`, which is re-sampled at every step load.
- **PLAY, counter = 0, `step_idx` = `last_step`:**
  - `loop`=1: wrap to index 0, load table[0], pulse `step_strobe`.
  - `loop`=0: go to IDLE, clear `ctrl_out` to 0, pulse `done`; no `step_strobe`.
- **`last_step` sampling.** Compared combinationally at the advance decision. If `last_step` < `step_idx` at that point, playback continues upward and wraps naturally at NUM_STEPS−1 → 0 before it can match.
- **`stop`:**
  - In PLAY: → IDLE on the next edge, `ctrl_out` ← 0, no `done` pulse.
  - `start` and `stop` in the same cycle: `stop` wins.
  - `start` while in PLAY is ignored; there is no restart.
- **Table writes.**
  - Accepted in any state.
  - A write to the address being loaded on the same edge: `ctrl_out` gets the OLD entry; the new value takes effect on the next visit.
  - A write never alters `ctrl_out` directly.
- **Reset mid-run:** returns to IDLE, clears the table, and is silent thereafter.

## Timing
- Start latency: `start` sampled at edge E0 → `ctrl_out` = table[0] from E0 onward (registered, visible in the following cycle).
- With held length L = max(`step_len`,1), step k is presented from edge E0+k·L. Each step is visible for exactly L cycles.
- `step_strobe` is high for the single cycle after each load edge. For L=1 it is high continuously while playing.
- One-shot finish: `done` and `busy`=0 occur at the edge E0+(`last_step`+1)·L, the same edge `ctrl_out` returns to 0.
- `stop` latency: 1 edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `nco_seq_pkg` holds:
  - Control-word field offsets and widths: `FILT_BIT`=15, `INCA_LSB`=8, `BYPB_BIT`=7, `AMPB_BIT`=6, `INCB_LSB`=0.
  - The FSM state enum {IDLE, PLAY}.
  - The constant `CTRL_W`=16.
- Sub-module `seq_step_table`: NUM_STEPS×16 register file with synchronous reset, one write port and one combinational read port. Reads return pre-write data within a cycle.
- The top module contains the FSM, the step-length counter and the output registers.

## Test plan
- Reset → all outputs 0. Write table[0..3] = 16'h8101, 16'h0202, 16'h0403, 16'h0804. `step_len`=3, `last_step`=3, `loop`=1, pulse `start` → `ctrl_out` walks 8101,0202,0403,0804,8101 with 3 cycles each. `step_strobe` fires every 3rd cycle.
- Same table with `loop`=0 → after 0804 is held 3 cycles, `ctrl_out`=0, `done` pulses once, `busy` falls at cycle 12 after start.
- `step_len`=0 and `step_len`=1 → each step is held exactly 1 cycle and `step_strobe` stays high while `busy`.
- `stop` asserted two cycles into step 2 → next cycle `ctrl_out`=0, `busy`=0, no `done`. Then `start` and `stop` together → stays IDLE.
- While step 1 plays, write table[2]=16'hFFFF on the cycle step 2 loads → `ctrl_out` shows the old table[2]. On the next loop pass it shows FFFF.
- Assert `rst_n`=0 mid-PLAY → next edge: all outputs 0 and the table is cleared. `start` afterwards plays all-zero words.
